// File: rtl/mem_async_requester.sv
// Clocked initiator for a dual-rail, 4-phase asynchronous memory port.
// One CPU request at a time is encoded, handshaken (set / return-to-zero) and answered.
module mem_async_requester #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  addr,
  output logic [15:0] data_in,
  output logic [1:0]  read_Nwrite,
  output logic        ack_in_read,
  input  logic [15:0] data_out,
  input  logic        ack_read,
  input  logic        ack_write
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, W_SET, W_RTZ, R_SET, R_CAPT, R_RTZ, DONE} state_t;

  function automatic logic [7:0] enc4(input logic [3:0] v);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = {v[i], ~v[i]};
    return r;
  endfunction

  function automatic logic [15:0] enc8(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = {v[i], ~v[i]};
    return r;
  endfunction

  function automatic logic [7:0] dec8(input logic [15:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[2*i+1];
    return r;
  endfunction

  function automatic logic has_illegal(input logic [15:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 8; i++) r = r | (v[2*i] & v[2*i+1]);
    return r;
  endfunction

  function automatic logic is_complete(input logic [15:0] v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < 8; i++) r = r & (v[2*i] | v[2*i+1]);
    return r;
  endfunction

  // Acks and read data are asynchronous to clk: resample through SYNC_STAGES flops.
  logic [17:0] sync_q [SYNC_STAGES];
  logic        ack_read_s;
  logic        ack_write_s;
  logic [15:0] data_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {ack_read, ack_write, data_out};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ack_read_s  = sync_q[SYNC_STAGES-1][17];
  assign ack_write_s = sync_q[SYNC_STAGES-1][16];
  assign data_s      = sync_q[SYNC_STAGES-1][15:0];

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [7:0]    addr_nxt, rsp_rdata_nxt;
  logic [15:0]   data_in_nxt;
  logic [1:0]    rnw_nxt;
  logic          ack_in_read_nxt, rsp_valid_nxt, rsp_err_nxt, req_ready_nxt;
  logic          set_expired;

  assign set_expired = (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt       = state;
    timer_nxt       = timer;
    addr_nxt        = addr;
    data_in_nxt     = data_in;
    rnw_nxt         = read_Nwrite;
    ack_in_read_nxt = ack_in_read;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    req_ready_nxt   = req_ready;
    case (state)
      IDLE: begin
        req_ready_nxt = 1'b1;
        if (req_valid) begin
          req_ready_nxt   = 1'b0;
          rsp_err_nxt     = 1'b0;
          timer_nxt       = '0;
          addr_nxt        = enc4(req_addr);
          ack_in_read_nxt = 1'b0;
          if (req_write) begin
            data_in_nxt = enc8(req_wdata);
            rnw_nxt     = 2'b01;
            state_nxt   = W_SET;
          end else begin
            data_in_nxt = '0;
            rnw_nxt     = 2'b10;
            state_nxt   = R_SET;
          end
        end
      end
      W_SET: begin
        if (ack_write_s || set_expired) begin
          rsp_err_nxt = rsp_err | ~ack_write_s;
          addr_nxt    = '0;
          data_in_nxt = '0;
          rnw_nxt     = 2'b00;
          state_nxt   = W_RTZ;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      W_RTZ: begin
        if (!ack_write_s) begin
          rsp_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end
      end
      R_SET: begin
        if (has_illegal(data_s)) rsp_err_nxt = 1'b1;
        if (ack_read_s && is_complete(data_s)) begin
          state_nxt = R_CAPT;
        end else if (set_expired) begin
          // Abort still runs the return-to-zero phase so the responder can settle.
          rsp_err_nxt     = 1'b1;
          addr_nxt        = '0;
          rnw_nxt         = 2'b00;
          ack_in_read_nxt = 1'b1;
          state_nxt       = R_RTZ;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      R_CAPT: begin
        rsp_rdata_nxt   = dec8(data_s);
        addr_nxt        = '0;
        rnw_nxt         = 2'b00;
        ack_in_read_nxt = 1'b1;
        state_nxt       = R_RTZ;
      end
      R_RTZ: begin
        if (!ack_read_s) begin
          ack_in_read_nxt = 1'b0;
          rsp_valid_nxt   = 1'b1;
          state_nxt       = DONE;
        end
      end
      DONE: begin
        req_ready_nxt = 1'b1;
        state_nxt     = IDLE;
      end
      default: begin
        addr_nxt        = '0;
        data_in_nxt     = '0;
        rnw_nxt         = 2'b00;
        ack_in_read_nxt = 1'b0;
        req_ready_nxt   = 1'b1;
        state_nxt       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      addr        <= '0;
      data_in     <= '0;
      read_Nwrite <= 2'b00;
      ack_in_read <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      req_ready   <= 1'b1;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      addr        <= addr_nxt;
      data_in     <= data_in_nxt;
      read_Nwrite <= rnw_nxt;
      ack_in_read <= ack_in_read_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      req_ready   <= req_ready_nxt;
    end
  end

endmodule

// File: tb/tb_mem_async_requester.sv
// Bench for mem_async_requester: behavioural async memory responder plus an
// array model of memory contents, driven with directed and random transactions.
module tb_mem_async_requester;

  localparam int S  = 2;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [7:0]  addr;
  logic [15:0] data_in;
  logic [1:0]  read_Nwrite;
  logic        ack_in_read;
  logic [15:0] data_out = '0;
  logic        ack_read = 1'b0;
  logic        ack_write = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  // Responder behaviour: 0 = normal, 1 = corrupt pair[1:0] to 11, 2 = never ack
  int         mode = 0;
  logic       force_en = 1'b0;
  logic [7:0] force_val = '0;
  logic [7:0] mem [16] = '{default: 8'h00};
  logic [7:0] ref_mem [16] = '{default: 8'h00};

  mem_async_requester #(.SYNC_STAGES(S), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .data_in(data_in), .read_Nwrite(read_Nwrite),
    .ack_in_read(ack_in_read), .data_out(data_out),
    .ack_read(ack_read), .ack_write(ack_write)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc4(input logic [3:0] v);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [15:0] enc8(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [3:0] dec4(input logic [7:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (v[2*i +: 2] == 2'b10);
    return r;
  endfunction

  function automatic logic [7:0] dec8(input logic [15:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (v[2*i +: 2] == 2'b10);
    return r;
  endfunction

  // Asynchronous memory: reacts half a cycle after the requester's outputs change.
  always @(negedge clk) begin
    if (read_Nwrite == 2'b01 && !ack_write && mode != 2) begin
      mem[dec4(addr)] = dec8(data_in);
      ack_write = 1'b1;
    end else if (read_Nwrite == 2'b00 && ack_write) begin
      ack_write = 1'b0;
    end
    if (read_Nwrite == 2'b10 && !ack_read && !ack_in_read && mode != 2) begin
      data_out = enc8(force_en ? force_val : mem[dec4(addr)]);
      if (mode == 1) data_out[1:0] = 2'b11;
      ack_read = 1'b1;
    end else if (read_Nwrite == 2'b00 && ack_read) begin
      ack_read = 1'b0;
      data_out = '0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  logic [7:0]  t_adr;
  logic [15:0] t_din;
  logic [1:0]  t_rnw;
  int          t_lat, t_spc, t_nvalid;
  logic        t_err, t_air_seen, t_air_end;
  logic [7:0]  t_rdata;

  task automatic run_txn(input logic w, input logic [3:0] a, input logic [7:0] d, input int budget);
    int k;
    k = 0;
    while (!req_ready && k < budget) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    t_adr = addr; t_din = data_in; t_rnw = read_Nwrite;
    t_lat = -1; t_spc = -1; t_nvalid = 0; t_air_seen = 1'b0; t_air_end = 1'b1;
    t_err = 1'bx; t_rdata = 'x;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (t_spc < 0 && read_Nwrite == 2'b00) t_spc = c;
      if (ack_in_read) t_air_seen = 1'b1;
      if (rsp_valid) begin
        t_nvalid++;
        if (t_lat < 0) begin
          t_lat = c; t_err = rsp_err; t_rdata = rsp_rdata; t_air_end = ack_in_read;
        end
      end
      if (t_lat >= 0 && c >= t_lat + 3) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({addr, data_in, read_Nwrite, ack_in_read} !== 27'd0) begin
      n_fail++; $display("FAIL reset_mem_side: addr=%h data_in=%h rnw=%b air=%b, required all 0", addr, data_in, read_Nwrite, ack_in_read); end
    n_cmp++; if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 11'b100_0000_0000) begin
      n_fail++; $display("FAIL reset_cpu_side: ready=%b valid=%b err=%b rdata=%h, required 1 0 0 00", req_ready, rsp_valid, rsp_err, rsp_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || read_Nwrite !== 2'b00) begin
      n_fail++; $display("FAIL reset_release: ready=%b rnw=%b, required 1 00", req_ready, read_Nwrite); end
  endtask

  task automatic test_write();
    mode = 0; force_en = 1'b0;
    run_txn(1'b1, 4'hA, 8'h5C, 60);
    ref_mem[4'hA] = 8'h5C;
    n_cmp++; if (t_adr !== 8'h99 || t_din !== 16'h66A5 || t_rnw !== 2'b01) begin
      n_fail++; $display("FAIL write_codeword: addr=%h data_in=%h rnw=%b, required 99 66a5 01", t_adr, t_din, t_rnw); end
    n_cmp++; if (t_lat < 1 || t_lat > 2*S+6) begin
      n_fail++; $display("FAIL write_latency: %0d clk, required 1..%0d", t_lat, 2*S+6); end
    n_cmp++; if (t_nvalid !== 1 || t_err !== 1'b0) begin
      n_fail++; $display("FAIL write_response: pulses=%0d err=%b, required 1 0", t_nvalid, t_err); end
    n_cmp++; if ({addr, data_in, read_Nwrite} !== 26'd0 || mem[4'hA] !== 8'h5C) begin
      n_fail++; $display("FAIL write_effect: addr=%h data_in=%h rnw=%b mem=%h, required spacer and 5c", addr, data_in, read_Nwrite, mem[4'hA]); end
  endtask

  task automatic test_read();
    mode = 0; force_en = 1'b1; force_val = 8'hB1;
    run_txn(1'b0, 4'h3, 8'h00, 60);
    force_en = 1'b0;
    n_cmp++; if (t_adr !== 8'h5A || t_rnw !== 2'b10 || t_din !== 16'h0000) begin
      n_fail++; $display("FAIL read_codeword: addr=%h rnw=%b data_in=%h, required 5a 10 0000", t_adr, t_rnw, t_din); end
    n_cmp++; if (t_rdata !== 8'hB1 || t_err !== 1'b0 || t_nvalid !== 1) begin
      n_fail++; $display("FAIL read_data: rdata=%h err=%b pulses=%0d, required b1 0 1", t_rdata, t_err, t_nvalid); end
    n_cmp++; if (t_air_seen !== 1'b1 || t_air_end !== 1'b0 || ack_read !== 1'b0) begin
      n_fail++; $display("FAIL read_ack_in: seen=%b at_rsp=%b ack_read=%b, required 1 0 0", t_air_seen, t_air_end, ack_read); end
    n_cmp++; if (t_lat < 1 || t_lat > 2*S+8) begin
      n_fail++; $display("FAIL read_latency: %0d clk, required 1..%0d", t_lat, 2*S+8); end
  endtask

  task automatic test_illegal();
    mode = 1;
    run_txn(1'b0, 4'hA, 8'h00, 60);
    mode = 0;
    n_cmp++; if (t_nvalid !== 1 || t_err !== 1'b1) begin
      n_fail++; $display("FAIL illegal_pair: pulses=%0d err=%b, required 1 1", t_nvalid, t_err); end
    n_cmp++; if (ack_read !== 1'b0 || ack_in_read !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL illegal_rtz: ack_read=%b air=%b ready=%b, required 0 0 1", ack_read, ack_in_read, req_ready); end
    run_txn(1'b0, 4'hA, 8'h00, 60);
    n_cmp++; if (t_err !== 1'b0 || t_rdata !== 8'h5C) begin
      n_fail++; $display("FAIL err_clears: err=%b rdata=%h, required 0 5c", t_err, t_rdata); end
  endtask

  task automatic test_timeout();
    mode = 2;
    run_txn(1'b1, 4'h6, 8'hE7, TO + 40);
    n_cmp++; if (t_spc < TO - 1 || t_spc > TO + 2) begin
      n_fail++; $display("FAIL wr_timeout_spacer: at %0d clk, required %0d..%0d", t_spc, TO - 1, TO + 2); end
    n_cmp++; if (t_nvalid !== 1 || t_err !== 1'b1) begin
      n_fail++; $display("FAIL wr_timeout_rsp: pulses=%0d err=%b, required 1 1", t_nvalid, t_err); end
    run_txn(1'b0, 4'h6, 8'h00, TO + 40);
    mode = 0;
    n_cmp++; if (t_nvalid !== 1 || t_err !== 1'b1 || t_air_seen !== 1'b1 || ack_in_read !== 1'b0) begin
      n_fail++; $display("FAIL rd_timeout: pulses=%0d err=%b air_seen=%b air=%b, required 1 1 1 0", t_nvalid, t_err, t_air_seen, ack_in_read); end
  endtask

  task automatic test_back_to_back();
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
    mode = 0; force_en = 1'b0;
    for (int n = 0; n < 24; n++) begin
      w = 1'($urandom_range(0, 1));
      a = 4'($urandom);
      d = 8'($urandom);
      run_txn(w, a, d, 60);
      n_cmp++; if (t_adr !== enc4(a) || t_rnw !== (w ? 2'b01 : 2'b10) || t_nvalid !== 1 || t_err !== 1'b0) begin
        n_fail++; $display("FAIL rand_txn%0d: addr=%h rnw=%b pulses=%0d err=%b, required %h %b 1 0", n, t_adr, t_rnw, t_nvalid, t_err, enc4(a), w ? 2'b01 : 2'b10); end
      if (w) begin
        ref_mem[a] = d;
        n_cmp++; if (t_din !== enc8(d)) begin
          n_fail++; $display("FAIL rand_wdata%0d: data_in=%h, required %h", n, t_din, enc8(d)); end
      end else begin
        n_cmp++; if (t_rdata !== ref_mem[a]) begin
          n_fail++; $display("FAIL rand_rdata%0d: addr %h rdata=%h, required %h", n, a, t_rdata, ref_mem[a]); end
      end
    end
  endtask

  task automatic test_busy_reset();
    logic hold_ok;
    int   k;
    mode = 0; force_en = 1'b0;
    ref_mem[4'h5] = mem[4'h5];
    k = 0;
    while (!req_ready && k < 60) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h5;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b1; req_addr = 4'hF; req_wdata = 8'h3C;
    hold_ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      if (read_Nwrite !== 2'b10 || addr !== enc4(4'h5) || req_ready !== 1'b0) hold_ok = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (hold_ok !== 1'b1) begin
      n_fail++; $display("FAIL busy_hold: rnw=%b addr=%h ready=%b, required 10 %h 0", read_Nwrite, addr, req_ready, enc4(4'h5)); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({addr, data_in, read_Nwrite, ack_in_read} !== 27'd0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_midread: addr=%h data_in=%h rnw=%b air=%b ready=%b, required spacer and ready", addr, data_in, read_Nwrite, ack_in_read, req_ready); end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while ((ack_read || ack_write) && k < 20) begin @(negedge clk); k++; end
    n_cmp++; if (ack_read !== 1'b0 || ack_write !== 1'b0 || read_Nwrite !== 2'b00) begin
      n_fail++; $display("FAIL reset_settle: ack_read=%b ack_write=%b rnw=%b, required 0 0 00", ack_read, ack_write, read_Nwrite); end
    run_txn(1'b0, 4'h5, 8'h00, 60);
    n_cmp++; if (t_nvalid !== 1 || t_err !== 1'b0 || t_rdata !== ref_mem[4'h5]) begin
      n_fail++; $display("FAIL post_reset_read: pulses=%0d err=%b rdata=%h, required 1 0 %h", t_nvalid, t_err, t_rdata, ref_mem[4'h5]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_busy_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
